// File: rtl/gf2m_mont_exp.sv
// gf2m_mont_exp: sequential G = A^E mod P(x) over GF(2^M), polynomial basis.
//
// Left-to-right square-and-multiply carried out in the Montgomery domain with
// a single combinational Montgomery multiplier used once per clock. The
// operand is mapped in with R2, the exponent bits are processed MSB first,
// and the accumulator is mapped back out by multiplying with 1.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready only in IDLE)
//   in_a [M-1:0]        base A
//   in_e [EW-1:0]       exponent E
//   out_valid/out_ready result handshake (held in DONE until out_ready)
//   out_g [M-1:0]       result, retained until the next FROM_MONT
//   busy                high in every state other than IDLE
module gf2m_mont_exp #(
    parameter int         M    = 3,
    parameter logic [M:0] POLY = 4'b1101,
    parameter int         EW   = 3,
    // x^M mod P: Montgomery image of 1
    parameter logic [M-1:0] R1 = 3'b101,
    // x^(2M) mod P; for x^3+x^2+1 this is x^6 = x^2+x
    parameter logic [M-1:0] R2 = 3'b110
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [M-1:0]  in_a,
    input  logic [EW-1:0] in_e,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [M-1:0]  out_g,
    output logic          busy
);

    localparam int IW = (EW > 1) ? $clog2(EW) : 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] TO_MONT   = 3'd1;
    localparam logic [2:0] SQUARE    = 3'd2;
    localparam logic [2:0] MULT      = 3'd3;
    localparam logic [2:0] FROM_MONT = 3'd4;
    localparam logic [2:0] DONE      = 3'd5;

    localparam logic [M-1:0] ONE = M'(1);

    // a*b*x^-M mod P, bit-serial right-shift form; result is fully reduced.
    function automatic logic [M-1:0] mont_mul(input logic [M-1:0] a,
                                              input logic [M-1:0] b);
        logic [M:0] c;
        c = '0;
        for (int i = 0; i < M; i++) begin
            if (a[i]) c = c ^ {1'b0, b};
            if (c[0]) c = c ^ POLY;
            c = c >> 1;
        end
        return c[M-1:0];
    endfunction

    logic [2:0]    state;
    logic [M-1:0]  a_reg;
    logic [M-1:0]  a_m;
    logic [M-1:0]  acc;
    logic [EW-1:0] e_reg;
    logic [IW-1:0] idx;

    logic [M-1:0]  mm_a;
    logic [M-1:0]  mm_b;
    logic [M-1:0]  mm_p;

    // Operand muxes for the single shared multiplier.
    always_comb begin
        mm_a = acc;
        mm_b = acc;
        case (state)
            TO_MONT:   begin mm_a = a_reg; mm_b = R2;  end
            SQUARE:    begin mm_a = acc;   mm_b = acc; end
            MULT:      begin mm_a = acc;   mm_b = a_m; end
            FROM_MONT: begin mm_a = acc;   mm_b = ONE; end
            default:   begin mm_a = acc;   mm_b = acc; end
        endcase
    end

    assign mm_p     = mont_mul(mm_a, mm_b);
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            a_m       <= '0;
            acc       <= '0;
            e_reg     <= '0;
            idx       <= '0;
            out_g     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
                        e_reg <= in_e;
                        acc   <= R1;
                        idx   <= IW'(EW - 1);
                        state <= TO_MONT;
                    end
                end
                TO_MONT: begin
                    a_m   <= mm_p;
                    state <= SQUARE;
                end
                SQUARE: begin
                    acc <= mm_p;
                    // A set bit is followed by a multiply before moving on;
                    // the index only advances once that bit is finished.
                    if (e_reg[idx]) begin
                        state <= MULT;
                    end else if (idx == '0) begin
                        state <= FROM_MONT;
                    end else begin
                        idx   <= idx - 1'b1;
                        state <= SQUARE;
                    end
                end
                MULT: begin
                    acc <= mm_p;
                    if (idx == '0) begin
                        state <= FROM_MONT;
                    end else begin
                        idx   <= idx - 1'b1;
                        state <= SQUARE;
                    end
                end
                FROM_MONT: begin
                    out_g     <= mm_p;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
